spdif_tx: RTL

S/PDIF (IEC 60958 consumer) transmitter: takes stereo 24-bit PCM sample pairs over a valid/ready handshake and emits a biphase-mark-coded serial stream. It generates B/M/W preambles, the 192-frame block structure, the validity and parity bits, and the channel-status bits. It is the transmit counterpart of the toi2s optical receive path. It loops recovered I2S audio back out as S/PDIF and serves as the bench stimulus source for the receiver.

---
 rtl/spdif_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spdif_tx.sv
// S/PDIF (IEC 60958 consumer) transmitter: stereo 24-bit PCM pairs in over valid/ready,
// biphase-mark serial stream out with B/M/W preambles, V/U/C/P bits and 192-frame blocks.
module spdif_tx #(
    parameter int CELL_DIV = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        ena,
    input  logic [23:0] left,
    input  logic [23:0] right,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [31:0] cs_lo,
    output logic        spdif_out,
    output logic        block_start,
    output logic        underrun
);

    localparam int            DW       = $clog2(CELL_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CELL_DIV - 1);

    // Preamble patterns as sent after a level of 0; inverted after a level of 1.
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    // Handshake: a pair transfers on every rising edge where sample_valid && sample_ready.
    // sample_ready is high while the one-entry buffer is empty and the block is enabled;
    // the source holds left/right stable while sample_valid waits for sample_ready.

    logic [DW-1:0] div_cnt;
    logic [6:0]    cell_cnt;
    logic [7:0]    frame_cnt;

    logic          tick;
    logic          frame_start;
    logic          accept;
    logic [5:0]    sub_cell;
    logic [4:0]    slot;
    logic          in_pre;
    logic          second_half;

    logic [7:0]    pre_pat;
    logic          pre_pol;
    logic          pre_bit;
    logic          c_bit;
    logic          slot_bit;
    logic          next_cell;

    logic          buf_full;
    logic [23:0]   buf_l;
    logic [23:0]   buf_r;
    logic [23:0]   sh_data;
    logic [23:0]   sh_right;
    logic          frame_v;
    logic          parity;
    logic          pre_inv;

    assign sample_ready = resetb & ena & ~buf_full;
    assign accept       = sample_valid & sample_ready;
    assign tick         = ena & (div_cnt == DIV_LAST);
    assign frame_start  = tick & (cell_cnt == 7'd0);
    assign sub_cell     = cell_cnt[5:0];
    assign slot         = sub_cell[5:1];
    assign second_half  = sub_cell[0];
    assign in_pre       = (sub_cell[5:3] == 3'd0);

    always_comb begin
        pre_pat = PRE_M;
        if (cell_cnt[6]) begin
            pre_pat = PRE_W;
        end else if (frame_cnt == 8'd0) begin
            pre_pat = PRE_B;
        end

        // Polarity is the level just before the preamble, held for all 8 cells.
        pre_pol = (sub_cell == 6'd0) ? spdif_out : pre_inv;
        pre_bit = pre_pat[~sub_cell[2:0]] ^ pre_pol;

        c_bit = (frame_cnt[7:5] == 3'd0) ? cs_lo[frame_cnt[4:0]] : 1'b0;

        slot_bit = 1'b0;
        case (slot)
            5'd28:   slot_bit = frame_v;
            5'd29:   slot_bit = 1'b0;
            5'd30:   slot_bit = c_bit;
            5'd31:   slot_bit = parity;
            default: slot_bit = sh_data[0];
        endcase

        if (in_pre) begin
            next_cell = pre_bit;
        end else if (second_half) begin
            next_cell = spdif_out ^ slot_bit;
        end else begin
            next_cell = ~spdif_out;
        end
    end

    // Cell divider and stream position counters.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            div_cnt   <= '0;
            cell_cnt  <= 7'd0;
            frame_cnt <= 8'd0;
        end else if (!ena) begin
            div_cnt   <= '0;
            cell_cnt  <= 7'd0;
            frame_cnt <= 8'd0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                cell_cnt <= cell_cnt + 7'd1;
                if (cell_cnt == 7'd127) begin
                    frame_cnt <= (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;
                end
            end
        end
    end

    // Serial output, payload shifter, parity accumulator and frame-start pulses.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            spdif_out   <= 1'b0;
            block_start <= 1'b0;
            underrun    <= 1'b0;
            sh_data     <= 24'd0;
            sh_right    <= 24'd0;
            frame_v     <= 1'b0;
            parity      <= 1'b0;
            pre_inv     <= 1'b0;
        end else if (!ena) begin
            spdif_out   <= 1'b0;
            block_start <= 1'b0;
            underrun    <= 1'b0;
            sh_data     <= 24'd0;
            sh_right    <= 24'd0;
            frame_v     <= 1'b0;
            parity      <= 1'b0;
            pre_inv     <= 1'b0;
        end else begin
            block_start <= frame_start & (frame_cnt == 8'd0);
            underrun    <= frame_start & ~buf_full;
            if (tick) begin
                spdif_out <= next_cell;

                if (sub_cell == 6'd0) begin
                    pre_inv <= spdif_out;
                    parity  <= 1'b0;
                end else if (!in_pre && !second_half && slot != 5'd31) begin
                    parity <= parity ^ slot_bit;
                end

                if (cell_cnt == 7'd0) begin
                    sh_data  <= buf_full ? buf_l : 24'd0;
                    sh_right <= buf_full ? buf_r : 24'd0;
                    frame_v  <= ~buf_full;
                end else if (cell_cnt == 7'd64) begin
                    sh_data <= sh_right;
                end else if (!in_pre && second_half && slot <= 5'd27) begin
                    sh_data <= {1'b0, sh_data[23:1]};
                end
            end
        end
    end

    // One-entry holding buffer; a frame-start transfer and an accept never coincide.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            buf_full <= 1'b0;
            buf_l    <= 24'd0;
            buf_r    <= 24'd0;
        end else if (!ena) begin
            buf_full <= 1'b0;
            buf_l    <= 24'd0;
            buf_r    <= 24'd0;
        end else if (frame_start && buf_full) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_l    <= left;
            buf_r    <= right;
        end
    end

endmodule
